// File: rtl/mem_pkg.sv
// Shared types for the RAM load path: lane widths, load-type encoding,
// FSM state encoding and small decode helpers.
package mem_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  // Width of the access being loaded
  typedef enum logic [1:0] {
    LD_WORD = 2'd0,
    LD_HALF = 2'd1,
    LD_BYTE = 2'd2
  } load_type_e;

  // Load sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Byte strobe wins over halfword strobe when both are raised
  function automatic load_type_e decode_type(input logic lb, input logic lh);
    if (lb) begin
      return LD_BYTE;
    end else if (lh) begin
      return LD_HALF;
    end
    return LD_WORD;
  endfunction

  // Byte loads can never be misaligned; halfwords need off[0]=0, words off=0
  function automatic logic misaligned(input load_type_e t, input logic [1:0] off);
    case (t)
      LD_BYTE: return 1'b0;
      LD_HALF: return off[0];
      default: return (off != 2'd0);
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational lane select and sign/zero extension of a little-endian
// RAM word for byte, halfword and word loads.
module load_extender
  import mem_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic [DATA_BITS-1:0] word_i,
  input  logic [1:0]           off_i,
  input  load_type_e           type_i,
  input  logic                 lu_i,
  output logic [DATA_BITS-1:0] value_o
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  // Pick the addressed byte and halfword lanes (byte n = bits 8n+7:8n)
  always_comb begin
    case (off_i)
      2'd0:    byte_sel = word_i[0*BYTE_W +: BYTE_W];
      2'd1:    byte_sel = word_i[1*BYTE_W +: BYTE_W];
      2'd2:    byte_sel = word_i[2*BYTE_W +: BYTE_W];
      default: byte_sel = word_i[3*BYTE_W +: BYTE_W];
    endcase
    half_sel = off_i[1] ? word_i[HALF_W +: HALF_W] : word_i[0 +: HALF_W];
  end

  // Extend the selected lane; the unsigned flag only matters for sub-word loads
  always_comb begin
    value_o = word_i;
    case (type_i)
      LD_BYTE: value_o = {{(DATA_BITS-BYTE_W){~lu_i & byte_sel[BYTE_W-1]}}, byte_sel};
      LD_HALF: value_o = {{(DATA_BITS-HALF_W){~lu_i & half_sel[HALF_W-1]}}, half_sel};
      default: value_o = word_i;
    endcase
  end

endmodule

// File: rtl/ram_output_adapter.sv
// Load-side RAM adapter: issues the word address, waits out the RAM read
// latency, extends the addressed lane and pulses load_valid for write-back.
// Optional misaligned-load flag enabled by defining LOAD_ALIGN_CHECK_EN.
module ram_output_adapter
  import mem_pkg::*;
#(
  parameter int ADDR_BITS     = 32,
  parameter int DATA_BITS     = 32,
  parameter int RAM_ADDR_BITS = 10,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [ADDR_BITS-1:0]     result1,
  input  logic                     Lb,
  input  logic                     Lh,
  input  logic                     Lu,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  input  logic [DATA_BITS-1:0]     ram_data,
  output logic [DATA_BITS-1:0]     load_data,
  output logic                     load_valid,
  output logic                     busy,
  output logic                     addr_err
);

  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  state_e                   state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [1:0]               off_q, off_d;
  load_type_e               type_q, type_d;
  logic                     lu_q, lu_d;
  logic [DATA_BITS-1:0]     load_data_q, load_data_d;
  logic                     err_q, err_d;
  logic [DATA_BITS-1:0]     ext_value;

  // Address bits above the RAM word address are not needed for a load
  if (ADDR_BITS > RAM_ADDR_BITS + 2) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^result1[ADDR_BITS-1:RAM_ADDR_BITS+2];
  end

  load_extender #(
    .DATA_BITS(DATA_BITS)
  ) u_ext (
    .word_i (ram_data),
    .off_i  (off_q),
    .type_i (type_q),
    .lu_i   (lu_q),
    .value_o(ext_value)
  );

  // State and datapath registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      off_q       <= '0;
      type_q      <= LD_WORD;
      lu_q        <= 1'b0;
      load_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      type_q      <= type_d;
      lu_q        <= lu_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
    end
  end

  // Next state: accept in IDLE, count down in WAIT, one cycle of DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 2'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latching, latency counter and result capture
  always_comb begin
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    off_d       = off_q;
    type_d      = type_q;
    lu_d        = lu_q;
    load_data_d = load_data_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = result1[RAM_ADDR_BITS+1:2];
          off_d  = result1[1:0];
          type_d = decode_type(Lb, Lh);
          lu_d   = Lu;
          cnt_d  = CNT_INIT;
`ifdef LOAD_ALIGN_CHECK_EN
          err_d  = misaligned(decode_type(Lb, Lh), result1[1:0]);
`else
          err_d  = 1'b0;
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          // A flagged misaligned load still completes but returns zero
          load_data_d = err_q ? '0 : ext_value;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE:  err_d = 1'b0;
      default: err_d = 1'b0;
    endcase
  end

  // Outputs: RAM address is live from the ALU while idle, latched otherwise
  always_comb begin
    ram_addr   = (state_q == S_IDLE) ? result1[RAM_ADDR_BITS+1:2] : addr_q;
    busy       = (state_q == S_WAIT);
    load_valid = (state_q == S_DONE);
  end

  assign load_data = load_data_q;
`ifdef LOAD_ALIGN_CHECK_EN
  assign addr_err = err_q;
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_output_adapter.sv
// Self-checking bench for ram_output_adapter: two instances (read latency 1
// and 3) each fed by a latency-accurate RAM model; results are compared to a
// behavioural load model. Define LOAD_ALIGN_CHECK_EN to exercise addr_err.
module tb_ram_output_adapter;

  logic        clk;
  logic        rst        [2];
  logic        req_valid  [2];
  logic [31:0] result1    [2];
  logic        lb         [2];
  logic        lh         [2];
  logic        lu         [2];
  logic [9:0]  ram_addr   [2];
  logic [31:0] ram_data   [2];
  logic [31:0] load_data  [2];
  logic        load_valid [2];
  logic        busy       [2];
  logic        addr_err   [2];

  logic [31:0] mem [2][1024];

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int RL = (gi == 0) ? 1 : 3;
      logic [9:0] pipe [4];

      ram_output_adapter #(
        .ADDR_BITS(32), .DATA_BITS(32), .RAM_ADDR_BITS(10), .READ_LATENCY(RL)
      ) u_dut (
        .clk(clk), .rst(rst[gi]), .req_valid(req_valid[gi]), .result1(result1[gi]),
        .Lb(lb[gi]), .Lh(lh[gi]), .Lu(lu[gi]), .ram_addr(ram_addr[gi]),
        .ram_data(ram_data[gi]), .load_data(load_data[gi]), .load_valid(load_valid[gi]),
        .busy(busy[gi]), .addr_err(addr_err[gi])
      );

      // RAM: address sampled every edge, data appears RL cycles later
      always @(posedge clk) begin
        pipe[0] <= ram_addr[gi];
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
        pipe[3] <= pipe[2];
      end
      assign ram_data[gi] = mem[gi][pipe[RL-1]];
    end
  endgenerate

  // Reference load: arithmetic lane extraction and extension
  function automatic logic [31:0] model(input logic [31:0] word, input logic [31:0] addr,
                                        input bit b, input bit h, input bit u, output bit err);
    int unsigned off, v;
    off = addr % 4;
    if (b) begin
      v = (word >> (8 * off)) % 256;
      if (!u && v >= 128) v = v + 32'hFFFF_FF00;
      err = 1'b0;
    end else if (h) begin
      v = (word >> (16 * (off / 2))) % 65536;
      if (!u && v >= 32768) v = v + 32'hFFFF_0000;
      err = (off % 2) == 1;
    end else begin
      v = word;
      err = (off != 0);
    end
`ifdef LOAD_ALIGN_CHECK_EN
    if (err) v = 0;
`else
    err = 1'b0;
`endif
    return v;
  endfunction

  task automatic do_load(input int i, input logic [31:0] addr, input bit b, input bit h,
                         input bit u, input logic [31:0] word, input string tag);
    logic [31:0] exp;
    bit          exp_err;
    int          cycles;
    int          rl;
    rl  = (i == 0) ? 1 : 3;
    exp = model(word, addr, b, h, u, exp_err);
    @(negedge clk);
    mem[i][addr[11:2]] = word;
    req_valid[i] = 1'b1; result1[i] = addr; lb[i] = b; lh[i] = h; lu[i] = u;
    #1;
    n_cmp++;
    if (busy[i] !== 1'b0 || ram_addr[i] !== addr[11:2]) begin
      n_err++;
      $display("FAIL %s idle: busy=%b ram_addr=%h, required busy=0 ram_addr=%h",
               tag, busy[i], ram_addr[i], addr[11:2]);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0; result1[i] = $urandom;
    lb[i] = 1'($urandom_range(0, 1)); lh[i] = 1'($urandom_range(0, 1)); lu[i] = 1'($urandom_range(0, 1));
    #1;
    cycles = 1;
    while (load_valid[i] !== 1'b1 && cycles <= 8) begin
      n_cmp++;
      if (busy[i] !== 1'b1 || ram_addr[i] !== addr[11:2]) begin
        n_err++;
        $display("FAIL %s wait: busy=%b ram_addr=%h, required busy=1 ram_addr=%h",
                 tag, busy[i], ram_addr[i], addr[11:2]);
      end
      @(negedge clk);
      cycles++;
    end
    n_cmp++;
    if (cycles != rl + 1) begin
      n_err++;
      $display("FAIL %s latency: load_valid after %0d cycles, required %0d", tag, cycles, rl + 1);
    end
    n_cmp++;
    if (load_data[i] !== exp || busy[i] !== 1'b0 || addr_err[i] !== exp_err) begin
      n_err++;
      $display("FAIL %s result: data=%h busy=%b addr_err=%b, required data=%h busy=0 addr_err=%b",
               tag, load_data[i], busy[i], addr_err[i], exp, exp_err);
    end
    $display("load %s inst=%0d addr=%h lb=%0d lh=%0d lu=%0d word=%h -> data=%h err=%b",
             tag, i, addr, b, h, u, word, load_data[i], addr_err[i]);
    @(negedge clk);
    n_cmp++;
    if (load_valid[i] !== 1'b0 || load_data[i] !== exp || addr_err[i] !== 1'b0) begin
      n_err++;
      $display("FAIL %s after: valid=%b data=%h addr_err=%b, required valid=0 data=%h addr_err=0",
               tag, load_valid[i], load_data[i], addr_err[i], exp);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; result1[i] = '0;
      lb[i] = 1'b0; lh[i] = 1'b0; lu[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0;
      result1[i] = 32'h0000_0ABC;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (load_data[i] !== 32'h0 || load_valid[i] !== 1'b0 || busy[i] !== 1'b0 ||
          addr_err[i] !== 1'b0 || ram_addr[i] !== 10'h2AF) begin
        n_err++;
        $display("FAIL reset inst%0d: data=%h valid=%b busy=%b err=%b ram_addr=%h, required 0/0/0/0/2af",
                 i, load_data[i], load_valid[i], busy[i], addr_err[i], ram_addr[i]);
      end
      $display("reset inst=%0d data=%h busy=%b", i, load_data[i], busy[i]);
    end
  endtask

  task automatic test_directed(input int i);
    do_load(i, 32'h0000_0004, 0, 0, 0, 32'h8765_4321, "word");
    do_load(i, 32'h0000_0007, 1, 0, 0, 32'h80FF_1234, "lb_signed");
    do_load(i, 32'h0000_0007, 1, 0, 1, 32'h80FF_1234, "lb_unsigned");
    do_load(i, 32'h0000_0002, 0, 1, 0, 32'h1234_8000, "lh_upper");
    do_load(i, 32'h0000_0000, 0, 1, 0, 32'h1234_8000, "lh_lower");
    do_load(i, 32'h0000_0FFC, 0, 1, 1, 32'h0000_F00F, "lh_unsigned_top");
    do_load(i, 32'h0000_0001, 1, 1, 0, 32'h0000_A500, "lb_priority");
    do_load(i, 32'hABCD_1006, 0, 0, 0, 32'h5A5A_0FF0, "high_addr_bits");
    do_load(i, 32'h0000_0003, 0, 1, 0, 32'hC0DE_0000, "lh_misaligned");
    do_load(i, 32'h0000_0003, 1, 0, 0, 32'h7F00_0000, "lb_off3");
    do_load(i, 32'h0000_0009, 0, 0, 0, 32'hCAFE_F00D, "word_misaligned");
  endtask

  task automatic test_random(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      do_load(i, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom, "random");
    end
  endtask

  task automatic test_back_to_back();
    int   pulses[$];
    logic prev_valid;
    bool_chk: begin end
    mem[1][5] = 32'h1111_2222;
    prev_valid = 1'b0;
    @(negedge clk);
    req_valid[1] = 1'b1; result1[1] = 32'h0000_0014; lb[1] = 1'b0; lh[1] = 1'b0; lu[1] = 1'b0;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (load_valid[1] === 1'b1) begin
        pulses.push_back(c);
        n_cmp++;
        if (prev_valid || load_data[1] !== 32'h1111_2222 || busy[1] !== 1'b0) begin
          n_err++;
          $display("FAIL b2b pulse c=%0d: prev_valid=%b data=%h busy=%b, required 0/11112222/0",
                   c, prev_valid, load_data[1], busy[1]);
        end
        $display("b2b load_valid at cycle %0d data=%h", c, load_data[1]);
      end
      prev_valid = load_valid[1];
    end
    req_valid[1] = 1'b0;
    n_cmp++;
    if (pulses.size() != 4) begin
      n_err++;
      $display("FAIL b2b count: %0d pulses, required 4", pulses.size());
    end
    for (int k = 0; k < pulses.size(); k++) begin
      n_cmp++;
      if (pulses[k] != 4 + 5 * k) begin
        n_err++;
        $display("FAIL b2b spacing: pulse %0d at cycle %0d, required %0d", k, pulses[k], 4 + 5 * k);
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    bit saw_valid;
    do_load(1, 32'h0000_0010, 0, 0, 0, 32'hDEAD_BEEF, "pre_reset");
    @(negedge clk);
    mem[1][4] = 32'h0BAD_0BAD;
    req_valid[1] = 1'b1; result1[1] = 32'h0000_0010; lb[1] = 1'b0; lh[1] = 1'b0; lu[1] = 1'b0;
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    n_cmp++;
    if (busy[1] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_wait busy_before: busy=%b, required 1", busy[1]);
    end
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    n_cmp++;
    if (busy[1] !== 1'b0 || load_data[1] !== 32'h0 || load_valid[1] !== 1'b0 || addr_err[1] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_wait after: busy=%b data=%h valid=%b err=%b, required 0/0/0/0",
               busy[1], load_data[1], load_valid[1], addr_err[1]);
    end
    saw_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (load_valid[1] !== 1'b0) saw_valid = 1'b1;
    end
    n_cmp++;
    if (saw_valid || load_data[1] !== 32'h0) begin
      n_err++;
      $display("FAIL rst_wait discard: load_valid seen=%b data=%h, required 0/0", saw_valid, load_data[1]);
    end
    $display("reset during wait: data=%h busy=%b", load_data[1], busy[1]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed(0);
    test_directed(1);
    test_back_to_back();
    test_reset_in_wait();
    test_random(0, 30);
    test_random(1, 30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_output_adapter.md
Name: ram_output_adapter

Overview:
- Load-side counterpart of the RAM store adapter. It issues the word address to the data RAM for a load and waits out the RAM read latency.
- It then extracts the addressed byte or halfword from the returned word, sign- or zero-extends it, and presents the result to regfile write-back with a one-cycle valid pulse.
- While a load is in flight it raises a busy/stall to the pipeline.

Parameters:
- ADDR_BITS, 32, width of the ALU address input (result1)
- DATA_BITS, 32, RAM data width; byte/halfword logic assumes 32
- RAM_ADDR_BITS, 10, RAM word-address width (ram_addr = result1[RAM_ADDR_BITS+1:2])
- READ_LATENCY, 1, cycles from ram_addr valid to ram_data valid (legal values 1..4)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  load request this cycle (accepted only when busy=0)
- result1  in  ADDR_BITS  ALU result, byte address of the load
- Lb  in  1  byte load
- Lh  in  1  halfword load
- Lu  in  1  unsigned (zero-extend) for Lb/Lh; ignored for word loads
- ram_addr  out  RAM_ADDR_BITS  RAM word address
- ram_data  in  DATA_BITS  RAM read data
- load_data  out  DATA_BITS  aligned, extended load result
- load_valid  out  1  one-cycle pulse, load_data valid
- busy  out  1  stall request to the pipeline
- addr_err  out  1  misaligned-load flag (optional feature only)

Behaviour:
- Reset: synchronous, active-high. When rst=1 at a clock edge:
  - state goes to IDLE; all latches and the counter clear
  - load_data=0, load_valid=0, busy=0, addr_err=0
  - a load in flight is discarded and no load_valid is issued
- States:
  - IDLE, WAIT, DONE
  - the FSM is a 2-bit register; the counter is 2 bits
- IDLE:
  - ram_addr = result1[RAM_ADDR_BITS+1:2] (combinational) and busy=0
  - req_valid=1 latches the address, off=result1[1:0] and the type (Lb, Lh, Lu)
  - cnt is loaded with READ_LATENCY-1 and the FSM goes to WAIT
- WAIT:
  - ram_addr is driven from the latched address; busy=1
  - if cnt=0, ram_data is captured, converted and registered into load_data, and the FSM goes to DONE; otherwise cnt decrements
- DONE:
  - load_valid=1 and busy=0 for exactly one cycle
  - the FSM returns to IDLE; load_data holds until the next capture
  - req_valid is ignored in DONE; the pipeline re-presents it in IDLE
- Latency: load_valid asserts READ_LATENCY+1 cycles after the accepting edge.
- Byte order is little-endian, matching the store adapter: byte n = data[8n+7:8n].
- Lb:
  - selects byte off
  - Lu=0 sign-extends from bit 7; Lu=1 zero-extends
- Lh:
  - selects halfword off[1] (bits 15:0 or 31:16)
  - Lu=0 sign-extends from bit 15; Lu=1 zero-extends
  - off[0] is ignored
- Neither Lb nor Lh: word load; load_data = ram_data.
- Lb and Lh both 1: Lb has priority.
- ram_data is sampled only in WAIT with cnt=0; it is don't-care at all other times.

Optional Feature:
- Macro: LOAD_ALIGN_CHECK_EN.
- Defined:
  - on acceptance, addr_err is registered high for a misaligned load: Lh with off[0]=1, or a word load with off!=0
  - addr_err is held through WAIT and asserted alongside load_valid in DONE
  - a misaligned load still completes and returns data forced to 0
  - addr_err clears on return to IDLE
- Undefined: addr_err is tied to 0 and low address bits are ignored as described above.

Decomposition:
- Shared package (mem_pkg):
  - localparams BYTE_W=8, HALF_W=16
  - a 2-bit load-type encoding (LD_WORD, LD_HALF, LD_BYTE)
  - the FSM state encoding (S_IDLE, S_WAIT, S_DONE)
- Sub-module load_extender (purely combinational): inputs are the word, off, type and Lu; output is the extended value. The FSM instantiates it once ahead of the load_data register.

Test Plan:
- READ_LATENCY=1: result1=32'h4, word load, ram_data=32'h8765_4321 → ram_addr=1, busy for 1 cycle, load_valid 2 cycles after accept, load_data=32'h8765_4321.
- Lb, Lu=0:
  - result1=32'h7, ram_data=32'h80FF_1234 → load_data=32'hFFFF_FF80
  - repeat with Lu=1 → 32'h0000_0080
- Lh, Lu=0:
  - result1=32'h2, ram_data=32'h1234_8000 → load_data=32'h0000_1234
  - result1=32'h0 → 32'hFFFF_8000
- READ_LATENCY=3: back-to-back requests with req_valid held high → second request accepted only after DONE; each load_valid is a single cycle; spacing is 5 cycles.
- rst=1 in WAIT → next cycle busy=0, load_valid never pulses, load_data=0.
- With LOAD_ALIGN_CHECK_EN:
  - Lh at result1=32'h3 → addr_err=1 with load_valid, load_data=0
  - Lb at 32'h3 → addr_err=0
